// File: rtl/jtframe_ptr_pkg.sv
// Shared definitions for the pointer/direction conditioning block.
// Holds the joystick direction bit indices, the default reset/step constants
// and the 9-to-8 bit saturating narrowing helper used on mouse deltas.
package jtframe_ptr_pkg;

    // Direction bit positions within a 4-bit joystick word
    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LF = 1;
    localparam int DIR_RT = 0;

    localparam logic [7:0] PADDLE_RST_DEF = 8'h80;
    localparam logic [7:0] JOY_STEP_DEF   = 8'd4;

    // Signed 9-bit to signed 8-bit, clipping to -128..+127.
    // The value fits in 8 bits exactly when the two top bits agree.
    function automatic logic [7:0] sat9to8(input logic [8:0] v);
        if (v[8] != v[7])
            return v[8] ? 8'h80 : 8'h7F;
        return v[7:0];
    endfunction

endpackage

// File: rtl/jtframe_4way_filt.sv
// One 8-to-4-way joystick filter.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   en4way      1 = filter diagonals, 0 = pass the raw input through
//   joy_in      raw directions {up, down, left, right}
//   joy_out     registered filtered directions, same bit order
module jtframe_4way_filt
    import jtframe_ptr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en4way,
    input  logic [3:0] joy_in,
    output logic [3:0] joy_out
);

    logic [3:0] out_q, out_d;
    logic       multi;

    // Clearing the lowest set bit leaves something only if >=2 bits are set
    assign multi = |(joy_in & (joy_in - 4'd1));

    always_comb begin
        out_d = out_q;
        if (!en4way || !multi) begin
            out_d = joy_in;
        end else if ((out_q & joy_in) == 4'd0) begin
            // Previous axis released: pick one direction by fixed priority
            if (joy_in[DIR_UP])      out_d = 4'b1000;
            else if (joy_in[DIR_DN]) out_d = 4'b0100;
            else if (joy_in[DIR_LF]) out_d = 4'b0010;
            else                     out_d = 4'b0001;
        end
        // otherwise a still-held previous direction stays selected
    end

    always_ff @(posedge clk) begin
        if (!rst_n) out_q <= 4'd0;
        else        out_q <= out_d;
    end

    assign joy_out = out_q;

endmodule

// File: rtl/jtframe_ptr_inputs.sv
// Pointer/direction conditioning for the input frame.
// - Four 8-to-4-way joystick filters (players 1-4), 1-cycle latency.
// - Mouse delta/button registers for players 1-2, loaded on mouse_st,
//   cleared while lock is high.
// - Absolute paddle position accumulated from mouse_dx, clamped to 0..255.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   en4way                  enable 4-way filtering
//   joy8way_Np / joy4way_Np raw / filtered directions per player
//   lock                    force mouse registers and buttons to 0
//   joy1, joy2              game joystick (only used for mouse emulation)
//   mouse_dx/dy/f/st/idx    incoming mouse event and its target player
//   mouse_1p/2p, but_1p/2p  {dy8, dx8} and buttons per player
//   paddle                  absolute paddle position
// Optional feature macro: JTFRAME_MOUSE_JOYEMU_EN -- when defined, a held
// joystick direction emulates mouse motion of +/-JOY_STEP per cycle.
module jtframe_ptr_inputs
    import jtframe_ptr_pkg::*;
#(
    parameter logic [7:0] PADDLE_RST = PADDLE_RST_DEF
`ifdef JTFRAME_MOUSE_JOYEMU_EN
   ,parameter logic [7:0] JOY_STEP   = JOY_STEP_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en4way,
    input  logic [3:0]  joy8way_1p,
    input  logic [3:0]  joy8way_2p,
    input  logic [3:0]  joy8way_3p,
    input  logic [3:0]  joy8way_4p,
    output logic [3:0]  joy4way_1p,
    output logic [3:0]  joy4way_2p,
    output logic [3:0]  joy4way_3p,
    output logic [3:0]  joy4way_4p,
    input  logic        lock,
    input  logic [3:0]  joy1,
    input  logic [3:0]  joy2,
    input  logic [8:0]  mouse_dx,
    input  logic [8:0]  mouse_dy,
    input  logic [7:0]  mouse_f,
    input  logic        mouse_st,
    input  logic        mouse_idx,
    output logic [15:0] mouse_1p,
    output logic [15:0] mouse_2p,
    output logic [2:0]  but_1p,
    output logic [2:0]  but_2p,
    output logic [7:0]  paddle
);

    // ---------------- 4-way filters ----------------
    logic [3:0][3:0] joy_raw, joy_flt;

    assign joy_raw = {joy8way_4p, joy8way_3p, joy8way_2p, joy8way_1p};

    jtframe_4way_filt u_filt [3:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .en4way  (en4way),
        .joy_in  (joy_raw),
        .joy_out (joy_flt)
    );

    assign joy4way_1p = joy_flt[0];
    assign joy4way_2p = joy_flt[1];
    assign joy4way_3p = joy_flt[2];
    assign joy4way_4p = joy_flt[3];

    // ---------------- mouse and paddle ----------------
    logic [15:0]       m1_q, m1_d, m2_q, m2_d;
    logic [2:0]        b1_q, b1_d, b2_q, b2_d;
    logic [7:0]        pad_q, pad_d;
    logic [7:0]        sdx, sdy;
    logic signed [9:0] pad_sum;

    assign sdx = sat9to8(mouse_dx);
    assign sdy = sat9to8(mouse_dy);

    // 10 bits hold 0..255 plus -256..255 without overflow
    assign pad_sum = $signed({2'b00, pad_q}) + $signed({mouse_dx[8], mouse_dx});

`ifdef JTFRAME_MOUSE_JOYEMU_EN
    logic [1:0] act_q, act_d;   // joystick was non-zero last cycle

    function automatic logic [15:0] joy_emu(input logic [3:0] j);
        logic [7:0] dx, dy;
        dx = 8'd0;
        dy = 8'd0;
        if (j[DIR_RT] && !j[DIR_LF]) dx = JOY_STEP;
        if (j[DIR_LF] && !j[DIR_RT]) dx = 8'd0 - JOY_STEP;
        if (j[DIR_UP] && !j[DIR_DN]) dy = JOY_STEP;
        if (j[DIR_DN] && !j[DIR_UP]) dy = 8'd0 - JOY_STEP;
        return {dy, dx};
    endfunction

    assign act_d = {joy2 != 4'd0, joy1 != 4'd0};

    always_ff @(posedge clk) begin
        if (!rst_n) act_q <= 2'b00;
        else        act_q <= act_d;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, mouse_f[7:3]};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, mouse_f[7:3], joy1, joy2};
`endif

    always_comb begin
        m1_d  = m1_q;
        m2_d  = m2_q;
        b1_d  = b1_q;
        b2_d  = b2_q;
        pad_d = pad_q;
`ifdef JTFRAME_MOUSE_JOYEMU_EN
        // Emulation only clears on the release edge so strobed values
        // persist while the joystick stays idle.
        if (joy1 != 4'd0)  m1_d = joy_emu(joy1);
        else if (act_q[0]) m1_d = 16'd0;
        if (joy2 != 4'd0)  m2_d = joy_emu(joy2);
        else if (act_q[1]) m2_d = 16'd0;
`endif
        if (mouse_st) begin
            if (pad_sum[9])      pad_d = 8'h00;
            else if (pad_sum[8]) pad_d = 8'hFF;
            else                 pad_d = pad_sum[7:0];
            if (!mouse_idx) begin
                m1_d = {sdy, sdx};
                b1_d = mouse_f[2:0];
            end else begin
                m2_d = {sdy, sdx};
                b2_d = mouse_f[2:0];
            end
        end
        if (lock) begin
            m1_d = 16'd0;
            m2_d = 16'd0;
            b1_d = 3'd0;
            b2_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m1_q  <= 16'd0;
            m2_q  <= 16'd0;
            b1_q  <= 3'd0;
            b2_q  <= 3'd0;
            pad_q <= PADDLE_RST;
        end else begin
            m1_q  <= m1_d;
            m2_q  <= m2_d;
            b1_q  <= b1_d;
            b2_q  <= b2_d;
            pad_q <= pad_d;
        end
    end

    assign mouse_1p = m1_q;
    assign mouse_2p = m2_q;
    assign but_1p   = b1_q;
    assign but_2p   = b2_q;
    assign paddle   = pad_q;

endmodule

// File: tb/tb_jtframe_ptr_inputs.sv
module tb_jtframe_ptr_inputs;

    logic        clk = 1'b0;
    logic        rst_n, en4way, lock, mouse_st, mouse_idx;
    logic [3:0]  j8_1, j8_2, j8_3, j8_4, j4_1, j4_2, j4_3, j4_4, joy1, joy2;
    logic [8:0]  mouse_dx, mouse_dy;
    logic [7:0]  mouse_f, paddle;
    logic [15:0] mouse_1p, mouse_2p;
    logic [2:0]  but_1p, but_2p;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtframe_ptr_inputs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en4way     (en4way),
        .joy8way_1p (j8_1),
        .joy8way_2p (j8_2),
        .joy8way_3p (j8_3),
        .joy8way_4p (j8_4),
        .joy4way_1p (j4_1),
        .joy4way_2p (j4_2),
        .joy4way_3p (j4_3),
        .joy4way_4p (j4_4),
        .lock       (lock),
        .joy1       (joy1),
        .joy2       (joy2),
        .mouse_dx   (mouse_dx),
        .mouse_dy   (mouse_dy),
        .mouse_f    (mouse_f),
        .mouse_st   (mouse_st),
        .mouse_idx  (mouse_idx),
        .mouse_1p   (mouse_1p),
        .mouse_2p   (mouse_2p),
        .but_1p     (but_1p),
        .but_2p     (but_2p),
        .paddle     (paddle)
    );

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic idx, input logic [8:0] dx, input logic [8:0] dy,
                          input logic [7:0] f);
        mouse_idx = idx; mouse_dx = dx; mouse_dy = dy; mouse_f = f; mouse_st = 1'b1;
        tick();
        mouse_st = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_j1"}, {12'd0, j4_1}, 16'd0);
        chk({tag, "_j2"}, {12'd0, j4_2}, 16'd0);
        chk({tag, "_j3"}, {12'd0, j4_3}, 16'd0);
        chk({tag, "_j4"}, {12'd0, j4_4}, 16'd0);
        chk({tag, "_m1"}, mouse_1p, 16'h0000);
        chk({tag, "_m2"}, mouse_2p, 16'h0000);
        chk({tag, "_b1"}, {13'd0, but_1p}, 16'd0);
        chk({tag, "_b2"}, {13'd0, but_2p}, 16'd0);
        chk({tag, "_pad"}, {8'd0, paddle}, 16'h0080);
    endtask

    initial begin
        rst_n = 1'b0; en4way = 1'b0; lock = 1'b0; mouse_st = 1'b0; mouse_idx = 1'b0;
        j8_1 = 4'd0; j8_2 = 4'd0; j8_3 = 4'd0; j8_4 = 4'd0; joy1 = 4'd0; joy2 = 4'd0;
        mouse_dx = 9'd0; mouse_dy = 9'd0; mouse_f = 8'd0;
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;

        // 4-way filter
        en4way = 1'b1;
        j8_1 = 4'b1000; j8_2 = 4'b0110; j8_3 = 4'b1100; j8_4 = 4'b0101;
        tick();
        chk("4w_up",      {12'd0, j4_1}, 16'h0008);
        chk("4w_dn_lf",   {12'd0, j4_2}, 16'h0004);
        chk("4w_up_dn",   {12'd0, j4_3}, 16'h0008);
        chk("4w_dn_rt",   {12'd0, j4_4}, 16'h0004);
        j8_1 = 4'b1001; j8_2 = 4'b0101;
        tick();
        chk("4w_sticky1", {12'd0, j4_1}, 16'h0008);
        chk("4w_sticky2", {12'd0, j4_2}, 16'h0004);
        j8_1 = 4'b0011;
        tick();
        chk("4w_lf_rt",   {12'd0, j4_1}, 16'h0002);
        en4way = 1'b0; j8_1 = 4'b1001;
        tick();
        chk("4w_pass",    {12'd0, j4_1}, 16'h0009);
        chk("4w_pass4",   {12'd0, j4_4}, 16'h0005);

        // Mouse strobe to player 1, dy saturates positive
        strobe(1'b0, 9'h1F4, 9'h0FF, 8'h05);
        chk("ms_m1",  mouse_1p, 16'h7FF4);
        chk("ms_b1",  {13'd0, but_1p}, 16'h0005);
        chk("ms_m2",  mouse_2p, 16'h0000);
        chk("ms_pad", {8'd0, paddle}, 16'h0074);
        tick();
        chk("ms_hold", mouse_1p, 16'h7FF4);

        // Player 2, dx saturates negative, upper flag bits ignored
        strobe(1'b1, 9'h100, 9'h005, 8'hFA);
        chk("ms2_m2",  mouse_2p, 16'h0580);
        chk("ms2_b2",  {13'd0, but_2p}, 16'h0002);
        chk("ms2_m1",  mouse_1p, 16'h7FF4);
        chk("ms2_pad", {8'd0, paddle}, 16'h0000);

        // Lock beats strobe, paddle still moves
        lock = 1'b1;
        strobe(1'b1, 9'h064, 9'h001, 8'h07);
        lock = 1'b0;
        chk("lk_m2",  mouse_2p, 16'h0000);
        chk("lk_b2",  {13'd0, but_2p}, 16'h0000);
        chk("lk_m1",  mouse_1p, 16'h0000);
        chk("lk_b1",  {13'd0, but_1p}, 16'h0000);
        chk("lk_pad", {8'd0, paddle}, 16'h0064);

        // Reset mid-operation (paddle and 4-way state are non-zero)
        rst_n = 1'b0;
        tick();
        chk_reset("mid");
        rst_n = 1'b1;
        j8_1 = 4'd0; j8_2 = 4'd0; j8_3 = 4'd0; j8_4 = 4'd0;

        // Paddle clamping from centre
        strobe(1'b0, 9'h064, 9'h000, 8'h00);
        chk("pd_e4", {8'd0, paddle}, 16'h00E4);
        strobe(1'b0, 9'h064, 9'h000, 8'h00);
        chk("pd_ff", {8'd0, paddle}, 16'h00FF);
        strobe(1'b0, 9'h100, 9'h000, 8'h00);
        chk("pd_00", {8'd0, paddle}, 16'h0000);
        strobe(1'b0, 9'h100, 9'h000, 8'h00);
        chk("pd_00b", {8'd0, paddle}, 16'h0000);
        chk("pd_m1",  mouse_1p, 16'h0080);

        // Joystick mouse emulation
        joy1 = 4'b1001;
        tick();
`ifdef JTFRAME_MOUSE_JOYEMU_EN
        chk("emu_on", mouse_1p, 16'h0404);
`else
        chk("emu_off", mouse_1p, 16'h0080);
`endif
        joy1 = 4'b0000;
        tick();
`ifdef JTFRAME_MOUSE_JOYEMU_EN
        chk("emu_rel", mouse_1p, 16'h0000);
`else
        chk("emu_off_rel", mouse_1p, 16'h0080);
`endif
        chk("emu_m2", mouse_2p, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
